// File: rtl/sound_latch_mailbox_if.sv
// 68K->Z80 sound command mailbox bus: 68K write side, Z80 read/clear side and status.
interface sound_latch_mailbox_if #(
    parameter int PTR_W = 1
);
    logic             m68k_latch_cs;
    logic             m68k_rw;
    logic             m68k_lds_n;
    logic [7:0]       m68k_dout;
    logic             z80_latch_r_cs;
    logic             z80_latch_clr_cs;
    logic             z80_rd_n;
    logic [7:0]       z80_latch_dout;
    logic             latch_pending;
    logic [PTR_W:0]   latch_count;
    logic             latch_overflow;

    modport master (
        output m68k_latch_cs, m68k_rw, m68k_lds_n, m68k_dout,
        output z80_latch_r_cs, z80_latch_clr_cs, z80_rd_n,
        input  z80_latch_dout, latch_pending, latch_count, latch_overflow
    );

    modport slave (
        input  m68k_latch_cs, m68k_rw, m68k_lds_n, m68k_dout,
        input  z80_latch_r_cs, z80_latch_clr_cs, z80_rd_n,
        output z80_latch_dout, latch_pending, latch_count, latch_overflow
    );
endinterface

// File: rtl/sound_latch_mailbox.sv
// Sound command mailbox: queues 68K latch writes, presents the oldest byte to the Z80,
// retires it on a latch-clear strobe. DEPTH=1 behaves as the original single latch.
module sound_latch_mailbox #(
    parameter int DEPTH = 1,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sound_latch_mailbox_if.slave   bus
);
    localparam logic [PTR_W-1:0] L_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   L_FULL = (PTR_W + 1)'(DEPTH);
    localparam int               MEM_N  = 1 << PTR_W;

    logic [7:0]       r_mem [MEM_N];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;
    logic             r_wr_q;
    logic             r_clr_q;

    logic             w_wr;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [7:0]       w_dout;
    logic             w_unused_rd;

    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        if (p == L_LAST) return {PTR_W{1'b0}};
        else             return p + PTR_W'(1);
    endfunction

    // Step back to the newest entry, wrapping modulo DEPTH.
    function automatic logic [PTR_W-1:0] f_ptr_dec(input logic [PTR_W-1:0] p);
        if (p == {PTR_W{1'b0}}) return L_LAST;
        else                    return p - PTR_W'(1);
    endfunction

    // Strobe decode and edge detection; reads are decode-only and carry no state.
    always_comb begin
        w_wr        = bus.m68k_latch_cs & ~bus.m68k_rw & ~bus.m68k_lds_n;
        w_push      = w_wr & ~r_wr_q;
        w_pop       = bus.z80_latch_clr_cs & ~r_clr_q;
        w_empty     = (r_count == {(PTR_W + 1){1'b0}});
        w_full      = (r_count == L_FULL);
        w_unused_rd = bus.z80_latch_r_cs & bus.z80_rd_n;
    end

    // Z80 sees the oldest queued byte, or zero when nothing is pending.
    always_comb begin
        if (!w_empty) begin
            w_dout = r_mem[r_rd_ptr];
        end else begin
            w_dout = 8'h00;
        end
    end

    // Queue state: push/pop with overwrite-on-full and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {(PTR_W + 1){1'b0}};
            r_overflow <= 1'b0;
            r_wr_q     <= 1'b0;
            r_clr_q    <= 1'b0;
            for (int i = 0; i < MEM_N; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            r_wr_q  <= w_wr;
            r_clr_q <= bus.z80_latch_clr_cs;
            if (w_push && w_pop && !w_empty) begin
                // Retire and enqueue together: never an overflow, count holds.
                r_mem[r_wr_ptr] <= bus.m68k_dout;
                r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
                r_rd_ptr        <= f_ptr_inc(r_rd_ptr);
            end else if (w_push && !w_full) begin
                r_mem[r_wr_ptr] <= bus.m68k_dout;
                r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
                r_count         <= r_count + (PTR_W + 1)'(1);
            end else if (w_push) begin
                r_mem[f_ptr_dec(r_wr_ptr)] <= bus.m68k_dout;
                r_overflow                 <= 1'b1;
            end else if (w_pop && !w_empty) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                r_count  <= r_count - (PTR_W + 1)'(1);
            end else begin
                r_count <= r_count;
            end
        end
    end

    assign bus.z80_latch_dout = w_dout;
    assign bus.latch_pending  = ~w_empty;
    assign bus.latch_count    = r_count;
    assign bus.latch_overflow = r_overflow;
endmodule

// File: tb/tb_sound_latch_mailbox.sv
// Self-checking bench: DEPTH=4, 1 and 2 mailboxes share one stimulus stream and are
// compared every cycle against a list-based model of the command queue.
module tb_sound_latch_mailbox;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs = 1'b0, rw = 1'b1, lds_n = 1'b1, r_cs = 1'b0, clr = 1'b0, rd_n = 1'b1;
    logic [7:0] d = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sound_latch_mailbox_if #(.PTR_W(2)) if4 ();
    sound_latch_mailbox_if #(.PTR_W(1)) if1 ();
    sound_latch_mailbox_if #(.PTR_W(1)) if2 ();

    assign if4.m68k_latch_cs = cs;  assign if1.m68k_latch_cs = cs;  assign if2.m68k_latch_cs = cs;
    assign if4.m68k_rw = rw;        assign if1.m68k_rw = rw;        assign if2.m68k_rw = rw;
    assign if4.m68k_lds_n = lds_n;  assign if1.m68k_lds_n = lds_n;  assign if2.m68k_lds_n = lds_n;
    assign if4.m68k_dout = d;       assign if1.m68k_dout = d;       assign if2.m68k_dout = d;
    assign if4.z80_latch_r_cs = r_cs; assign if1.z80_latch_r_cs = r_cs; assign if2.z80_latch_r_cs = r_cs;
    assign if4.z80_latch_clr_cs = clr; assign if1.z80_latch_clr_cs = clr; assign if2.z80_latch_clr_cs = clr;
    assign if4.z80_rd_n = rd_n;     assign if1.z80_rd_n = rd_n;     assign if2.z80_rd_n = rd_n;

    sound_latch_mailbox #(.DEPTH(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(if4.slave));
    sound_latch_mailbox #(.DEPTH(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
    sound_latch_mailbox #(.DEPTH(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(if2.slave));

    // Model: per instance, an ordered list of queued bytes (index 0 = oldest).
    int         depth_of [3] = '{4, 1, 2};
    logic [7:0] mq [3][8];
    int         msz [3];
    bit         movf [3];
    bit         m_wr_q, m_clr_q, m_wr, m_push, m_pop;

    initial begin
        for (int k = 0; k < 3; k++) begin
            msz[k] = 0; movf[k] = 1'b0;
        end
        m_wr_q = 1'b0; m_clr_q = 1'b0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                for (int k = 0; k < 3; k++) begin
                    msz[k] = 0; movf[k] = 1'b0;
                end
                m_wr_q = 1'b0; m_clr_q = 1'b0;
            end else begin
                m_wr   = cs && !rw && !lds_n;
                m_push = m_wr && !m_wr_q;
                m_pop  = clr && !m_clr_q;
                for (int k = 0; k < 3; k++) begin
                    if (m_pop && msz[k] > 0) begin
                        for (int j = 0; j < 7; j++) mq[k][j] = mq[k][j+1];
                        msz[k] = msz[k] - 1;
                    end
                    if (m_push) begin
                        if (msz[k] < depth_of[k]) begin
                            mq[k][msz[k]] = d;
                            msz[k] = msz[k] + 1;
                        end else begin
                            mq[k][msz[k]-1] = d;
                            movf[k] = 1'b1;
                        end
                    end
                end
                m_wr_q  = m_wr;
                m_clr_q = clr;
            end
        end
    end

    function automatic int exp_dout(input int k);
        if (msz[k] > 0) return int'(mq[k][0]);
        else            return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT against the model on the falling edge.
    always @(negedge clk) begin
        chk("m4_count", int'(if4.latch_count), msz[0]);
        chk("m4_dout", int'(if4.z80_latch_dout), exp_dout(0));
        chk("m4_pend", int'(if4.latch_pending), int'(msz[0] != 0));
        chk("m4_ovf", int'(if4.latch_overflow), int'(movf[0]));
        chk("m1_count", int'(if1.latch_count), msz[1]);
        chk("m1_dout", int'(if1.z80_latch_dout), exp_dout(1));
        chk("m1_pend", int'(if1.latch_pending), int'(msz[1] != 0));
        chk("m1_ovf", int'(if1.latch_overflow), int'(movf[1]));
        chk("m2_count", int'(if2.latch_count), msz[2]);
        chk("m2_dout", int'(if2.z80_latch_dout), exp_dout(2));
        chk("m2_pend", int'(if2.latch_pending), int'(msz[2] != 0));
        chk("m2_ovf", int'(if2.latch_overflow), int'(movf[2]));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] v, input int hold);
        cs = 1'b1; rw = 1'b0; lds_n = 1'b0; d = v;
        cyc(hold);
        cs = 1'b0; rw = 1'b1; lds_n = 1'b1;
        cyc(1);
    endtask

    task automatic clr_pulse();
        clr = 1'b1; cyc(1);
        clr = 1'b0; cyc(1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; #2;
        reset_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        cyc(2);
        chk("rst_count", int'(if4.latch_count), 0);
        chk("rst_dout", int'(if4.z80_latch_dout), 8'h00);
        reset_n = 1'b1;
        cyc(1);

        // Long strobe: one push only, data visible one clk after the edge.
        cs = 1'b1; rw = 1'b0; lds_n = 1'b0; d = 8'h5A;
        cyc(1);
        chk("long_dout", int'(if4.z80_latch_dout), 8'h5A);
        chk("long_pend", int'(if4.latch_pending), 1);
        cyc(5);
        cs = 1'b0; rw = 1'b1; lds_n = 1'b1;
        cyc(1);
        chk("long_count", int'(if4.latch_count), 1);

        // Asynchronous reset with two bytes queued, checked before any clock edge.
        wr_byte(8'h77, 1);
        chk("pre_rst_count", int'(if4.latch_count), 2);
        reset_n = 1'b0; #1;
        chk("arst_count", int'(if4.latch_count), 0);
        chk("arst_dout", int'(if4.z80_latch_dout), 8'h00);
        chk("arst_pend", int'(if4.latch_pending), 0);
        chk("arst_ovf", int'(if4.latch_overflow), 0);
        #1 reset_n = 1'b1;
        cyc(1);

        // Reads are non-destructive; clears retire in order.
        wr_byte(8'h11, 1); wr_byte(8'h22, 1); wr_byte(8'h33, 1);
        for (int i = 0; i < 3; i++) begin
            r_cs = 1'b1; rd_n = 1'b0; cyc(1);
            r_cs = 1'b0; rd_n = 1'b1; cyc(1);
        end
        chk("rd_dout", int'(if4.z80_latch_dout), 8'h11);
        chk("rd_count", int'(if4.latch_count), 3);
        clr_pulse(); chk("clr1_dout", int'(if4.z80_latch_dout), 8'h22);
        clr_pulse(); chk("clr2_dout", int'(if4.z80_latch_dout), 8'h33);
        clr_pulse(); chk("clr3_dout", int'(if4.z80_latch_dout), 8'h00);
        chk("clr3_count", int'(if4.latch_count), 0);
        clr_pulse(); chk("clr4_count", int'(if4.latch_count), 0);
        chk("clr4_dout", int'(if4.z80_latch_dout), 8'h00);

        // Overwrite on the single-entry latch.
        do_reset();
        wr_byte(8'h10, 1); wr_byte(8'h20, 1);
        chk("ovw_count", int'(if1.latch_count), 1);
        chk("ovw_dout", int'(if1.z80_latch_dout), 8'h20);
        chk("ovw_ovf", int'(if1.latch_overflow), 1);
        clr_pulse();
        chk("ovw_clr_dout", int'(if1.z80_latch_dout), 8'h00);
        chk("ovw_clr_ovf", int'(if1.latch_overflow), 1);

        // Simultaneous push and pop on a full DEPTH=2 queue.
        do_reset();
        wr_byte(8'hA1, 1); wr_byte(8'hA2, 1);
        chk("sim_full", int'(if2.latch_count), 2);
        cs = 1'b1; rw = 1'b0; lds_n = 1'b0; d = 8'hA3; clr = 1'b1;
        cyc(1);
        chk("sim_count", int'(if2.latch_count), 2);
        chk("sim_dout", int'(if2.z80_latch_dout), 8'hA2);
        chk("sim_ovf", int'(if2.latch_overflow), 0);
        cs = 1'b0; rw = 1'b1; lds_n = 1'b1; clr = 1'b0;
        cyc(1);
        clr_pulse();
        chk("sim_next", int'(if2.z80_latch_dout), 8'hA3);
        chk("sim_ovf2", int'(if2.latch_overflow), 0);

        // Pointer wrap-around on DEPTH=4.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_byte(8'(i), 1);
            chk("wrap_dout", int'(if4.z80_latch_dout), i);
            chk("wrap_count1", int'(if4.latch_count), 1);
            clr_pulse();
            chk("wrap_count0", int'(if4.latch_count), 0);
        end

        // Randomized traffic, occasional mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            cs    = ($urandom_range(0, 2) != 0);
            rw    = ($urandom_range(0, 3) == 0);
            lds_n = ($urandom_range(0, 5) == 0);
            d     = 8'($urandom_range(0, 255));
            clr   = ($urandom_range(0, 2) == 0);
            r_cs  = 1'($urandom_range(0, 1));
            rd_n  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0; #2;
                reset_n = 1'b1;
            end
            cyc(1);
        end

        cs = 1'b0; clr = 1'b0; r_cs = 1'b0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sound_latch_mailbox.md
Name: sound_latch_mailbox

Overview:
- Receiving end of the 68K→Z80 sound command path.
- Accepts byte writes from the 68K through the sound-latch chip select and queues them in a small FIFO.
- Presents the oldest byte to the Z80 on the latch-read I/O port.
- Retires that byte when the Z80 writes the latch-clear I/O port. With DEPTH=1 this is exactly the single cleared latch of the original PCB.

Parameters:
- DEPTH, 1, number of queued command bytes; power of two, 1..8.
- PTR_W, $clog2(DEPTH) with a minimum of 1, pointer width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m68k_latch_cs  in  1  sound latch select, already qualified by AS.
- m68k_rw  in  1  68K R/W (1 = read).
- m68k_lds_n  in  1  68K lower data strobe.
- m68k_dout  in  8  68K data bus bits [7:0].
- z80_latch_r_cs  in  1  Z80 I/O read strobe for port 0x06, already qualified by IORQ.
- z80_latch_clr_cs  in  1  Z80 I/O strobe for port 0x04.
- z80_rd_n  in  1  Z80 RD_n; qualifies latch reads.
- z80_latch_dout  out  8  byte driven to the Z80 data mux.
- latch_pending  out  1  FIFO non-empty.
- latch_count  out  PTR_W+1  number of queued bytes.
- latch_overflow  out  1  sticky; set when a write arrives while the FIFO is full.

Behaviour:
- Reset (async, reset_n=0):
  - pointers, count, overflow, edge registers = 0;
  - z80_latch_dout=0, latch_pending=0.
  - Reset asserted mid-operation discards all queued bytes immediately.
- Write strobe:
  - wr = m68k_latch_cs & !m68k_rw & !m68k_lds_n.
  - A push fires on the clk where wr=1 and wr_q=0 (wr_q is wr registered).
  - Exactly one push per bus cycle, however long the strobe is held.
- Clear strobe:
  - A pop fires on the rising edge of z80_latch_clr_cs, detected the same way.
- Reads:
  - z80_latch_r_cs is non-destructive; it never changes state.
  - z80_latch_dout = mem[rd_ptr] when count>0, else 0x00.
  - Output is combinational from registers, so valid the cycle after a push lands.
  - z80_rd_n is decode-only; no side effect.
- Push, not full: mem[wr_ptr] <= m68k_dout, wr_ptr++, count++.
- Push, full, no pop (overwrite, matching the original latch):
  - mem[wr_ptr-1] <= m68k_dout, i.e. the newest entry is overwritten;
  - pointers and count unchanged;
  - latch_overflow <= 1.
- Pop, count>0: rd_ptr++, count--.
- Pop, empty: no effect (no underflow, output stays 0x00).
- Push and pop on the same clk:
  - if count>0: both take effect, count unchanged, no overflow even when full;
  - if count=0: the push takes effect and the pop is ignored, count becomes 1.
- Pointers wrap modulo DEPTH; count saturates at DEPTH.
- latch_overflow clears only on reset.
- latch_pending = (count != 0).
- Latency:
  - 68K write to data visible on z80_latch_dout: 1 clk after the strobe edge;
  - clear to next byte visible: 1 clk.

Test Plan:
- Reset: hold reset_n=0 mid-queue with count=2 → count=0, z80_latch_dout=0x00, latch_pending=0, latch_overflow=0 with no clock edge.
- Long write strobe (DEPTH=4): 68K writes 0x5A with the strobe held 6 clks → exactly one push; count=1; z80_latch_dout=0x5A one clk after the strobe edge; latch_pending=1.
- Non-destructive read, then clear (DEPTH=4): write 0x11, 0x22, 0x33; pulse z80_latch_r_cs 3 times → dout stays 0x11, count=3. Clear pulses → dout 0x22, then 0x33, then 0x00 with count=0. A fourth clear → no change.
- Overwrite (DEPTH=1): write 0x10 then 0x20 with no clear → count=1, dout=0x20, latch_overflow=1. Clear → dout=0x00, overflow still 1.
- Simultaneous push/pop (DEPTH=2, full with 0xA1,0xA2): push 0xA3 and clear edge on the same clk → count=2, dout=0xA2, then 0xA3 after the next clear, overflow=0.
- Wrap-around (DEPTH=4): 10 sequential write/clear pairs with values 0x00..0x09 → each value read back in order; count returns to 0 after each clear.
